// File: rtl/sar_seq_pkg.sv
// Shared state encodings and width helper for the SAR feature sequencer.
package sar_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SAMPLE  = 3'd1;
    localparam logic [2:0] ST_CONVERT = 3'd2;
    localparam logic [2:0] ST_STORE   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Counter width for values 0..value-1, never less than one bit.
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/sar_feature_sequencer_bit_engine.sv
// Successive-approximation search for one conversion: trial/result registers
// and a down-counting bit pointer, MSB first.
module sar_bit_engine
    import sar_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         comp_gt,
    output logic [N-1:0] trial,
    output logic [N-1:0] result,
    output logic         last
);

    localparam int BW = clog2w(N);
    localparam logic [BW-1:0] MSB_IDX = BW'(N - 1);

    logic [BW-1:0] bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            bit_idx <= MSB_IDX;
        end else if (load) begin
            result  <= '0;
            bit_idx <= MSB_IDX;
        end else if (step) begin
            result[bit_idx] <= comp_gt;
            // Pointer parks at bit 0; the next load rearms it for the next feature.
            if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
        end
    end

    assign trial = result | (N'(1) << bit_idx);
    assign last  = (bit_idx == '0);

endmodule

// File: rtl/sar_feature_sequencer.sv
// Frame sequencer for the SAR front-end: mux select, sample/hold, SAR search and
// feature-vector assembly. Optional FEAT_SKIP_EN adds a per-feature skip mask.
//
//  state   | meaning
//  IDLE    | waiting for start, all outputs low
//  SAMPLE  | channel selected, sample_hold tracking for SETTLE_CYCLES
//  CONVERT | N comparator trials, MSB first
//  STORE   | write result (or 0 when skipped) into the vector, advance feature
//  DONE    | vec_valid held until vec_ready
module sar_feature_sequencer
    import sar_seq_pkg::*;
#(
    parameter int N             = 4,
    parameter int NUM_FEAT      = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  comp_gt,
    output logic [NUM_FEAT-1:0]   mux_sel,
    output logic                  sample_hold,
    output logic [N-1:0]          dac_code,
    output logic                  busy,
    output logic [NUM_FEAT*N-1:0] vec_data,
    output logic                  vec_valid,
    input  logic                  vec_ready
`ifdef FEAT_SKIP_EN
    ,
    input  logic [NUM_FEAT-1:0]   feat_mask
`endif
);

    localparam int FW = clog2w(NUM_FEAT);
    localparam int SW = clog2w(SETTLE_CYCLES);
    localparam logic [FW-1:0] LAST_FEAT  = FW'(NUM_FEAT - 1);
    localparam logic [SW-1:0] SETTLE_TOP = SW'(SETTLE_CYCLES - 1);

    logic [2:0]          state, state_nxt;
    logic [FW-1:0]       feat_idx, next_idx;
    logic [SW-1:0]       settle_cnt;
    logic [NUM_FEAT-1:0] mask_in, mask_q;
    logic [N-1:0]        trial, result, store_val;
    logic                conv_last, frame_start, last_feat;
    logic [2:0]          first_route, next_route;

`ifdef FEAT_SKIP_EN
    assign mask_in = feat_mask;
`else
    assign mask_in = '1;
`endif

    sar_bit_engine #(.N(N)) u_bit_engine (
        .clk     (clk),
        .rst     (rst),
        .load    (state == ST_STORE),
        .step    (state == ST_CONVERT),
        .comp_gt (comp_gt),
        .trial   (trial),
        .result  (result),
        .last    (conv_last)
    );

    assign last_feat   = (feat_idx == LAST_FEAT);
    assign next_idx    = feat_idx + 1'b1;
    assign frame_start = ((state == ST_IDLE) && start) ||
                         ((state == ST_DONE) && vec_ready && cont);
    // Masked-off features go straight to STORE so they still cost one cycle.
    assign first_route = mask_in[0] ? ST_SAMPLE : ST_STORE;
    assign next_route  = (!last_feat && mask_q[next_idx]) ? ST_SAMPLE : ST_STORE;
    assign store_val   = mask_q[feat_idx] ? result : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = first_route;
            ST_SAMPLE:  if (settle_cnt == '0) state_nxt = ST_CONVERT;
            ST_CONVERT: if (conv_last) state_nxt = ST_STORE;
            ST_STORE:   state_nxt = last_feat ? ST_DONE : next_route;
            ST_DONE:    if (vec_ready) state_nxt = cont ? first_route : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            feat_idx   <= '0;
            settle_cnt <= SETTLE_TOP;
            mask_q     <= '0;
            vec_data   <= '0;
        end else begin
            state <= state_nxt;

            if (frame_start) mask_q <= mask_in;

            if (frame_start || ((state == ST_DONE) && vec_ready))
                feat_idx <= '0;
            else if ((state == ST_STORE) && !last_feat)
                feat_idx <= next_idx;

            if (state != ST_SAMPLE)
                settle_cnt <= SETTLE_TOP;
            else if (settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;

            if (state == ST_STORE) vec_data[feat_idx*N +: N] <= store_val;
        end
    end

    // Outputs decode from state so an asynchronous reset clears them immediately.
    always_comb begin
        mux_sel = '0;
        if ((state == ST_SAMPLE) || (state == ST_CONVERT))
            mux_sel = NUM_FEAT'(1) << feat_idx;
    end

    assign sample_hold = (state == ST_SAMPLE);
    assign dac_code    = (state == ST_CONVERT) ? trial : '0;
    assign busy        = (state != ST_IDLE);
    assign vec_valid   = (state == ST_DONE);

endmodule

// File: tb/tb_sar_feature_sequencer.sv
// Scoreboard bench for sar_feature_sequencer: comparator modelled from per-channel
// analog codes, expected vectors queued at frame launch and checked at handoff.
module tb_sar_feature_sequencer;

    localparam int N   = 4;
    localparam int NF  = 10;
    localparam int ST  = 2;
    localparam int FRAME_LAT = NF * (ST + N + 1) + 1;

    logic              clk = 1'b0;
    logic              rst, start, cont, comp_gt, vec_ready;
    logic [NF-1:0]     mux_sel;
    logic              sample_hold, busy, vec_valid;
    logic [N-1:0]      dac_code;
    logic [NF*N-1:0]   vec_data;
`ifdef FEAT_SKIP_EN
    logic [NF-1:0]     feat_mask;
`endif

    logic [N-1:0]      ana [NF];
    logic [NF*N-1:0]   exp_q [$];
    logic [N-1:0]      dac_log [$];
    int                sh_total;
    int                n_checks = 0;
    int                n_errors = 0;

    sar_feature_sequencer #(.N(N), .NUM_FEAT(NF), .SETTLE_CYCLES(ST)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cont        (cont),
        .comp_gt     (comp_gt),
        .mux_sel     (mux_sel),
        .sample_hold (sample_hold),
        .dac_code    (dac_code),
        .busy        (busy),
        .vec_data    (vec_data),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready)
`ifdef FEAT_SKIP_EN
        ,
        .feat_mask   (feat_mask)
`endif
    );

    always #5 clk = ~clk;

    // Analog level is ana[k] + half an LSB, so the search lands exactly on ana[k].
    always_comb begin
        comp_gt = 1'b0;
        for (int k = 0; k < NF; k++)
            if (mux_sel[k]) comp_gt = (ana[k] >= dac_code);
    end

    initial sh_total = 0;
    always @(negedge clk) begin
        if (sample_hold) sh_total <= sh_total + 1;
        if (busy && mux_sel[3] && !sample_hold) dac_log.push_back(dac_code);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [NF*N-1:0] exp_vec(input logic [NF-1:0] m);
        logic [NF*N-1:0] v;
        v = '0;
        for (int k = 0; k < NF; k++)
            if (m[k]) v[k*N +: N] = ana[k];
        return v;
    endfunction

    task automatic launch(input logic [NF-1:0] m);
        exp_q.push_back(exp_vec(m));
`ifdef FEAT_SKIP_EN
        feat_mask = m;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called one negedge after the launching edge; counts that as cycle 1.
    task automatic collect(input string tag, input int lat);
        int cyc;
        logic [NF*N-1:0] e;
        cyc = 1;
        while (!vec_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_valid"}, 64'(vec_valid), 64'(1));
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_vec"}, 64'(vec_data), 64'(e));
        end
    endtask

    task automatic handshake();
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
    endtask

    initial begin
        int sh0, lg0, bad;
        logic [NF*N-1:0] held;

        rst = 1'b1; start = 1'b0; cont = 1'b0; vec_ready = 1'b0;
`ifdef FEAT_SKIP_EN
        feat_mask = '1;
`endif
        for (int k = 0; k < NF; k++) ana[k] = N'(NF - 1 - k);
        repeat (3) @(negedge clk);
        check("rst_mux", 64'(mux_sel), 64'(0));
        check("rst_sh", 64'(sample_hold), 64'(0));
        check("rst_dac", 64'(dac_code), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(vec_valid), 64'(0));
        check("rst_vec", 64'(vec_data), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Frame A: descending codes 9..0, latency and sample/hold duty.
        sh0 = sh_total;
        launch('1);
        check("a_busy", 64'(busy), 64'(1));
        check("a_mux0", 64'(mux_sel), 64'(1));
        collect("a", FRAME_LAT);
        check("a_sh_cycles", 64'(sh_total - sh0), 64'(NF * ST));
        handshake();
        check("a_valid_drop", 64'(vec_valid), 64'(0));
        check("a_idle", 64'(busy), 64'(0));

        // Frame B: ch3 = 1010 trial sequence, then a stalled handoff.
        for (int k = 0; k < NF; k++) ana[k] = N'($urandom_range(0, 15));
        ana[3] = 4'b1010;
        lg0 = dac_log.size();
        launch('1);
        collect("b", FRAME_LAT);
        check("b_dac_n", 64'(dac_log.size() - lg0), 64'(4));
        if (dac_log.size() >= lg0 + 4) begin
            check("b_dac0", 64'(dac_log[lg0]),     64'(4'b1000));
            check("b_dac1", 64'(dac_log[lg0 + 1]), 64'(4'b1100));
            check("b_dac2", 64'(dac_log[lg0 + 2]), 64'(4'b1010));
            check("b_dac3", 64'(dac_log[lg0 + 3]), 64'(4'b1011));
        end
        check("b_ch3", 64'(vec_data[3*N +: N]), 64'(4'b1010));
        held = vec_data;
        bad = 0;
        start = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!vec_valid || vec_data !== held || sample_hold || mux_sel != '0) bad++;
        end
        start = 1'b0;
        check("b_hold_stable", 64'(bad), 64'(0));
        handshake();
        check("b_idle", 64'(busy), 64'(0));

        // Frames C/D: continuous mode, restart with no idle cycle.
        for (int k = 0; k < NF; k++) ana[k] = 4'hF;
        cont = 1'b1;
        launch('1);
        collect("c", FRAME_LAT);
        for (int k = 0; k < NF; k++) ana[k] = N'(k * 3 + 1);
        exp_q.push_back(exp_vec('1));
        handshake();
        check("c_restart_mux", 64'(mux_sel), 64'(1));
        check("c_restart_sh", 64'(sample_hold), 64'(1));
        check("c_valid_drop", 64'(vec_valid), 64'(0));
        collect("d", FRAME_LAT);
        cont = 1'b0;
        handshake();
        check("d_idle", 64'(busy), 64'(0));

        // Frame E: all-zero comparator, then reset mid-CONVERT on feature 5.
        for (int k = 0; k < NF; k++) ana[k] = 4'h0;
        launch('1);
        bad = 0;
        while (!(mux_sel[5] && !sample_hold) && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        check("e_reach_f5", 64'(mux_sel[5] & ~sample_hold), 64'(1));
        rst = 1'b1;
        #1;
        check("e_rst_mux", 64'(mux_sel), 64'(0));
        check("e_rst_dac", 64'(dac_code), 64'(0));
        check("e_rst_busy", 64'(busy), 64'(0));
        check("e_rst_vec", 64'(vec_data), 64'(0));
        check("e_rst_sh", 64'(sample_hold), 64'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NF; k++) ana[k] = N'($urandom_range(0, 15));
        launch('1);
        collect("f", FRAME_LAT);
        handshake();

`ifdef FEAT_SKIP_EN
        // Skip mask: only features 0 and 2 converted.
        for (int k = 0; k < NF; k++) ana[k] = N'(k + 5);
        launch(10'b0000000101);
        collect("g", 2 * (ST + N + 1) + (NF - 2) + 1);
        handshake();
        launch('0);
        collect("h", NF + 1);
        handshake();
        feat_mask = '1;
`endif

        check("q_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
